// File: rtl/ctrl_pipe_tracker_if.sv
`default_nettype none
// ============================================================================
// ctrl_pipe_tracker_if : decode-side inputs and stage-control outputs of the
//                        pipeline control tracker.       Rev 1.0
// ============================================================================
interface ctrl_pipe_tracker_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [6:0]       id_ex_control;
  logic [1:0]       id_mem_control;
  logic [1:0]       id_wb_control;
  logic             id_unrecognized;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             ex_branch_taken;
  logic             stall;
  logic             flush_id;
  logic [1:0]       ex_alu_src1;
  logic [1:0]       ex_alu_src2;
  logic [1:0]       ex_alu_op;
  logic             ex_branch;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             mem_read;
  logic             mem_write;
  logic [4:0]       mem_rd;
  logic             wb_mem_to_reg;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic             illegal_trap;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output id_valid, id_ex_control, id_mem_control, id_wb_control,
           id_unrecognized, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  stall, flush_id, ex_alu_src1, ex_alu_src2, ex_alu_op, ex_branch,
           ex_rs1, ex_rs2, ex_rd, forward_a, forward_b, mem_read, mem_write,
           mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd, illegal_trap,
           retired_count
  );

  modport slave (
    input  id_valid, id_ex_control, id_mem_control, id_wb_control,
           id_unrecognized, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall, flush_id, ex_alu_src1, ex_alu_src2, ex_alu_op, ex_branch,
           ex_rs1, ex_rs2, ex_rd, forward_a, forward_b, mem_read, mem_write,
           mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd, illegal_trap,
           retired_count
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_tracker.sv
`default_nettype none
// ============================================================================
// ctrl_pipe_tracker : carries decoded control through EX/MEM/WB, detects
//                     load-use hazards, forwards operands, traps, retires.
// Rev 1.0
// ============================================================================
module ctrl_pipe_tracker #(
  parameter int CNT_W = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ctrl_pipe_tracker_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } mem_wb_t;

  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic             illegal_trap_q, illegal_trap_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;

  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             stall;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input ex_mem_t m, input mem_wb_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && rs != 5'd0) begin
      if (m.valid && m.reg_write && m.rd == rs)
        sel = 2'b10;
      else if (w.valid && w.reg_write && w.rd == rs)
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    id_use_rs1 = (bus.id_ex_control[6:5] == 2'b10);
    id_use_rs2 = (bus.id_ex_control[4:3] == 2'b00) || bus.id_mem_control[0];

    stall = bus.id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
            ((id_use_rs1 && bus.id_rs1 == id_ex_q.rd) ||
             (id_use_rs2 && bus.id_rs2 == id_ex_q.rd)) &&
            !bus.ex_branch_taken;

    id_ex_d = '0;
    if (!bus.ex_branch_taken && !stall && bus.id_valid && !bus.id_unrecognized) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.alu_src1   = bus.id_ex_control[6:5];
      id_ex_d.alu_src2   = bus.id_ex_control[4:3];
      id_ex_d.alu_op     = bus.id_ex_control[2:1];
      id_ex_d.branch     = bus.id_ex_control[0];
      id_ex_d.mem_read   = bus.id_mem_control[1];
      id_ex_d.mem_write  = bus.id_mem_control[0];
      id_ex_d.mem_to_reg = bus.id_wb_control[1];
      id_ex_d.reg_write  = bus.id_wb_control[0];
      id_ex_d.use_rs1    = id_use_rs1;
      id_ex_d.use_rs2    = id_use_rs2;
      id_ex_d.rs1        = bus.id_rs1;
      id_ex_d.rs2        = bus.id_rs2;
      id_ex_d.rd         = bus.id_rd;
    end

    illegal_trap_d = bus.id_valid && bus.id_unrecognized && !bus.ex_branch_taken && !stall;

    // Bubbles are all-zero, so a plain copy advances them correctly.
    ex_mem_d.valid      = id_ex_q.valid;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.rd         = id_ex_q.rd;

    mem_wb_d.valid      = ex_mem_q.valid;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.rd         = ex_mem_q.rd;

    retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, mem_wb_q.valid};

    forward_a = fwd_sel(id_ex_q.use_rs1, id_ex_q.rs1, ex_mem_q, mem_wb_q);
    forward_b = fwd_sel(id_ex_q.use_rs2, id_ex_q.rs2, ex_mem_q, mem_wb_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q         <= '0;
      ex_mem_q        <= '0;
      mem_wb_q        <= '0;
      illegal_trap_q  <= 1'b0;
      retired_count_q <= '0;
    end else begin
      id_ex_q         <= id_ex_d;
      ex_mem_q        <= ex_mem_d;
      mem_wb_q        <= mem_wb_d;
      illegal_trap_q  <= illegal_trap_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush_id      = bus.ex_branch_taken;
  assign bus.ex_alu_src1   = id_ex_q.alu_src1;
  assign bus.ex_alu_src2   = id_ex_q.alu_src2;
  assign bus.ex_alu_op     = id_ex_q.alu_op;
  assign bus.ex_branch     = id_ex_q.branch;
  assign bus.ex_rs1        = id_ex_q.rs1;
  assign bus.ex_rs2        = id_ex_q.rs2;
  assign bus.ex_rd         = id_ex_q.rd;
  assign bus.forward_a     = forward_a;
  assign bus.forward_b     = forward_b;
  assign bus.mem_read      = ex_mem_q.mem_read;
  assign bus.mem_write     = ex_mem_q.mem_write;
  assign bus.mem_rd        = ex_mem_q.rd;
  assign bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;
  assign bus.wb_reg_write  = mem_wb_q.reg_write;
  assign bus.wb_rd         = mem_wb_q.rd;
  assign bus.illegal_trap  = illegal_trap_q;
  assign bus.retired_count = retired_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_tracker.sv
`default_nettype none
// ============================================================================
// tb_ctrl_pipe_tracker : directed + random stimulus against a stage-list
//                        reference model; a 4-bit counter copy covers wrap.
// Rev 1.0
// ============================================================================
module tb_ctrl_pipe_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_pipe_tracker_if #(.CNT_W(32)) bus ();
  ctrl_pipe_tracker_if #(.CNT_W(4))  bus4 ();

  ctrl_pipe_tracker #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  ctrl_pipe_tracker #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  localparam logic [6:0] C_ADD  = 7'b10_00_10_0;
  localparam logic [6:0] C_ADDI = 7'b10_01_10_0;
  localparam logic [6:0] C_LW   = 7'b10_01_00_0;
  localparam logic [6:0] C_SW   = 7'b10_01_00_0;
  localparam logic [6:0] C_BEQ  = 7'b10_00_01_1;

  typedef struct {
    bit       v;
    bit [6:0] exc;
    bit [1:0] memc;
    bit [1:0] wbc;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } instr_t;

  instr_t          pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  longint unsigned m_retired;
  bit              m_trap;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [6:0] exc, input bit [1:0] memc,
                       input bit [1:0] wbc, input bit unrec, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit [4:0] rd, input bit br);
    bus.id_valid = v;          bus4.id_valid = v;
    bus.id_ex_control = exc;   bus4.id_ex_control = exc;
    bus.id_mem_control = memc; bus4.id_mem_control = memc;
    bus.id_wb_control = wbc;   bus4.id_wb_control = wbc;
    bus.id_unrecognized = unrec; bus4.id_unrecognized = unrec;
    bus.id_rs1 = rs1;          bus4.id_rs1 = rs1;
    bus.id_rs2 = rs2;          bus4.id_rs2 = rs2;
    bus.id_rd = rd;            bus4.id_rd = rd;
    bus.ex_branch_taken = br;  bus4.ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(0, 7'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  function automatic bit reads_rs1(bit [6:0] c);
    return c[6:5] == 2'b10;
  endfunction

  function automatic bit reads_rs2(bit [6:0] c, bit [1:0] m);
    return (c[4:3] == 2'b00) || m[0];
  endfunction

  function automatic bit exp_stall();
    bit hit;
    hit = (reads_rs1(bus.id_ex_control) && bus.id_rs1 == pipe[0].rd) ||
          (reads_rs2(bus.id_ex_control, bus.id_mem_control) && bus.id_rs2 == pipe[0].rd);
    return bus.id_valid && pipe[0].v && pipe[0].memc[1] && pipe[0].rd != 0 &&
           hit && !bus.ex_branch_taken;
  endfunction

  function automatic bit [1:0] exp_fwd(bit used, bit [4:0] rs);
    if (!used || rs == 0) return 2'b00;
    if (pipe[1].v && pipe[1].wbc[0] && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].v && pipe[2].wbc[0] && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: '0};
    m_retired = 0;
    m_trap    = 0;
  endtask

  task automatic check_outputs();
    chk("stall",       bus.stall,         exp_stall());
    chk("flush_id",    bus.flush_id,      bus.ex_branch_taken);
    chk("ex_alu_src1", bus.ex_alu_src1,   pipe[0].exc[6:5]);
    chk("ex_alu_src2", bus.ex_alu_src2,   pipe[0].exc[4:3]);
    chk("ex_alu_op",   bus.ex_alu_op,     pipe[0].exc[2:1]);
    chk("ex_branch",   bus.ex_branch,     pipe[0].exc[0]);
    chk("ex_rs1",      bus.ex_rs1,        pipe[0].rs1);
    chk("ex_rs2",      bus.ex_rs2,        pipe[0].rs2);
    chk("ex_rd",       bus.ex_rd,         pipe[0].rd);
    chk("forward_a",   bus.forward_a,
        exp_fwd(pipe[0].v && reads_rs1(pipe[0].exc), pipe[0].rs1));
    chk("forward_b",   bus.forward_b,
        exp_fwd(pipe[0].v && reads_rs2(pipe[0].exc, pipe[0].memc), pipe[0].rs2));
    chk("mem_read",    bus.mem_read,      pipe[1].memc[1]);
    chk("mem_write",   bus.mem_write,     pipe[1].memc[0]);
    chk("mem_rd",      bus.mem_rd,        pipe[1].rd);
    chk("wb_mem_to_reg", bus.wb_mem_to_reg, pipe[2].wbc[1]);
    chk("wb_reg_write",  bus.wb_reg_write,  pipe[2].wbc[0]);
    chk("wb_rd",       bus.wb_rd,         pipe[2].rd);
    chk("illegal_trap", bus.illegal_trap, m_trap);
    chk("retired32",   bus.retired_count, m_retired % (64'd1 << 32));
    chk("retired4",    bus4.retired_count, m_retired % 64'd16);
  endtask

  task automatic model_update();
    bit s;
    if (!rst_n) begin
      model_clear();
    end else begin
      s = exp_stall();
      m_retired += pipe[2].v;
      m_trap = bus.id_valid && bus.id_unrecognized && !bus.ex_branch_taken && !s;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (bus.id_valid && !bus.id_unrecognized && !bus.ex_branch_taken && !s)
        pipe[0] = '{1'b1, bus.id_ex_control, bus.id_mem_control, bus.id_wb_control,
                    bus.id_rs1, bus.id_rs2, bus.id_rd};
      else
        pipe[0] = '{default: '0};
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  int unsigned r;

  initial begin
    // Reset with garbage on the decode inputs
    rst_n = 1'b0;
    drive(1, 7'h5a, 2'b11, 2'b11, 1, 5'd3, 5'd3, 5'd3, 0);
    @(posedge clk);
    #1;
    model_clear();
    cycle();
    chk("rst_retired", bus.retired_count, 0);
    chk("rst_wb_rw",   bus.wb_reg_write, 0);
    chk("rst_trap",    bus.illegal_trap, 0);

    // ADD x3,x1,x2 latency
    rst_n = 1'b1;
    drive(1, C_ADD, 2'b00, 2'b01, 0, 5'd1, 5'd2, 5'd3, 0);
    cycle();
    chk("add_ex_src1", bus.ex_alu_src1, 2'b10);
    chk("add_ex_op",   bus.ex_alu_op,   2'b10);
    nop();
    cycle();
    cycle();
    chk("add_wb_rw", bus.wb_reg_write, 1);
    cycle();
    chk("add_retired", bus.retired_count, 1);

    // LW x5 ; ADD x6,x5,x1 load-use
    drive(1, C_LW, 2'b10, 2'b11, 0, 5'd1, 5'd0, 5'd5, 0);
    cycle();
    drive(1, C_ADD, 2'b00, 2'b01, 0, 5'd5, 5'd1, 5'd6, 0);
    #1;
    chk("lu_stall_on", bus.stall, 1);
    cycle();
    chk("lu_bubble_rd", bus.ex_rd, 0);
    chk("lu_stall_off", bus.stall, 0);
    cycle();
    chk("lu_fwd_a", bus.forward_a, 2'b01);
    nop();
    repeat (3) cycle();

    // ADDI x7 ; SW with rs2 = x7, then with a gap, then with x0
    drive(1, C_ADDI, 2'b00, 2'b01, 0, 5'd1, 5'd0, 5'd7, 0);
    cycle();
    drive(1, C_SW, 2'b01, 2'b00, 0, 5'd2, 5'd7, 5'd0, 0);
    cycle();
    chk("sw_fwd_mem", bus.forward_b, 2'b10);
    drive(1, C_ADDI, 2'b00, 2'b01, 0, 5'd1, 5'd0, 5'd7, 0);
    cycle();
    nop();
    cycle();
    drive(1, C_SW, 2'b01, 2'b00, 0, 5'd2, 5'd7, 5'd0, 0);
    cycle();
    chk("sw_fwd_wb", bus.forward_b, 2'b01);
    drive(1, C_ADDI, 2'b00, 2'b01, 0, 5'd1, 5'd0, 5'd0, 0);
    cycle();
    drive(1, C_SW, 2'b01, 2'b00, 0, 5'd2, 5'd0, 5'd0, 0);
    cycle();
    chk("sw_fwd_x0", bus.forward_b, 2'b00);
    nop();
    repeat (3) cycle();

    // Taken branch overrides a pending load-use stall
    drive(1, C_BEQ, 2'b00, 2'b00, 0, 5'd1, 5'd2, 5'd0, 0);
    cycle();
    drive(1, C_LW, 2'b10, 2'b11, 0, 5'd1, 5'd0, 5'd5, 1);
    #1;
    chk("br_flush", bus.flush_id, 1);
    cycle();
    drive(1, C_LW, 2'b10, 2'b11, 0, 5'd1, 5'd0, 5'd5, 0);
    cycle();
    drive(1, C_ADD, 2'b00, 2'b01, 0, 5'd5, 5'd1, 5'd6, 1);
    #1;
    chk("br_flush2", bus.flush_id, 1);
    chk("br_no_stall", bus.stall, 0);
    cycle();
    chk("br_bubble", bus.ex_alu_src1, 0);
    nop();
    repeat (3) cycle();

    // Illegal opcode: single, back-to-back, and held off by a stall
    drive(1, C_ADD, 2'b00, 2'b01, 1, 5'd1, 5'd2, 5'd9, 0);
    cycle();
    chk("ill_pulse", bus.illegal_trap, 1);
    chk("ill_no_ex", bus.ex_rd, 0);
    cycle();
    chk("ill_b2b", bus.illegal_trap, 1);
    nop();
    cycle();
    chk("ill_end", bus.illegal_trap, 0);
    drive(1, C_LW, 2'b10, 2'b11, 0, 5'd1, 5'd0, 5'd5, 0);
    cycle();
    drive(1, C_ADD, 2'b00, 2'b01, 1, 5'd5, 5'd1, 5'd6, 0);
    cycle();
    chk("ill_stalled", bus.illegal_trap, 0);
    cycle();
    chk("ill_after", bus.illegal_trap, 1);
    nop();
    repeat (3) cycle();

    // Random traffic with occasional mid-flight reset; small index range
    // keeps hazards frequent and the 4-bit counter wraps many times.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      rst_n = ($urandom_range(0, 79) != 0);
      drive($urandom_range(0, 3) != 0,
            7'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 9) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
      cycle();
    end

    rst_n = 1'b1;
    nop();
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_tracker.md
# ctrl_pipe_tracker

Carries the decoded control bundles (ex_control, mem_control, wb_control) from decode down the EX, MEM and WB stages. It detects load-use hazards and produces EX-stage operand forwarding selects. It also converts unrecognized opcodes into a trap pulse and counts retired instructions. It sits between the decode-stage control unit and the execute, memory and writeback datapath.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_ex_control  in  7  {alu_src1[6:5], alu_src2[4:3], alu_op[2:1], branch[0]}
- id_mem_control  in  2  {mem_read, mem_write}
- id_wb_control  in  2  {mem_to_reg, reg_write}
- id_unrecognized  in  1  opcode not decodable
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- stall  out  1  hold PC and IF/ID; combinational
- flush_id  out  1  kill IF/ID contents; equals ex_branch_taken
- ex_alu_src1, ex_alu_src2, ex_alu_op  out  2 each  EX-stage control
- ex_branch  out  1  EX-stage branch
- ex_rs1, ex_rs2, ex_rd  out  5 each  EX-stage indices
- forward_a, forward_b  out  2 each  00 regfile, 01 WB result, 10 MEM result
- mem_read, mem_write  out  1 each  MEM-stage control
- mem_rd  out  5  MEM-stage destination
- wb_mem_to_reg, wb_reg_write  out  1 each  WB-stage control
- wb_rd  out  5  WB-stage destination
- illegal_trap  out  1  one-cycle pulse on illegal-opcode capture
- retired_count  out  CNT_W  count of valid instructions that left WB

## Operation
- The block holds three stage registers: ID/EX, EX/MEM and MEM/WB. Each has a valid bit, its control fields and its register indices. A bubble is valid=0 with all control fields and indices zero.
- Operand usage is decoded from id_ex_control:
  - uses_rs1 = (alu_src1 == 2'b10).
  - uses_rs2 = (alu_src2 == 2'b00) OR mem_write.
- Load-use stall: stall = id_valid & EXvalid & mem_read(EX) & ex_rd != 0 & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)) & !ex_branch_taken.
- ID/EX capture priority, highest first:
  1. ex_branch_taken → bubble.
  2. stall → bubble.
  3. id_valid & id_unrecognized → bubble, and illegal_trap = 1 next cycle.
  4. id_valid → capture the bundle.
  5. Otherwise → bubble.
- The EX/MEM and MEM/WB registers always advance; stall and flush do not affect them. A taken branch in EX still advances to MEM with its own control, since branch bundles carry no mem or wb effects.
- Forwarding for EX operand A, against ex_rs1 when the EX instruction uses rs1:
  - 10 if MEMvalid & reg_write(MEM) & mem_rd != 0 & mem_rd == ex_rs1.
  - Otherwise 01 if WBvalid & wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1.
  - Otherwise 00.
  - The MEM match takes priority over the WB match.
- forward_b uses the same rules with ex_rs2 and the rs2-usage bit held in ID/EX.
- The EX/MEM stage carries an internal reg_write for forwarding and passes it on to WB.
- retired_count increments by 1 each cycle that MEM/WB valid = 1. It wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n = 0 at a clk edge) clears all valid bits, control fields, indices, illegal_trap and retired_count.
  - stall and forward_* are 0 during reset because they are gated by the valid bits.
  - Reset asserted mid-flight discards every in-flight instruction in the same edge.
- Latency: a bundle captured at edge N appears on the ex_* outputs after edge N, on mem_* after N+1, and on wb_* after N+2.
  - retired_count reflects that instruction after edge N+3.
- stall and flush_id are combinational and valid in the same cycle as the condition.
- A load-use stall lasts exactly one cycle: the load moves to MEM and the condition clears.
- illegal_trap is high for exactly one cycle. Back-to-back unrecognized instructions give back-to-back pulses.
- An unrecognized opcode that arrives together with a taken branch or a stall is not trapped in that cycle.
- Index 0 never produces a stall or a forward.

## Test plan
- Reset with garbage on the inputs → all outputs 0 and retired_count = 0. Release reset, issue ADD x3,x1,x2 → ex_alu_src1 = 10, ex_alu_op = 10 after 1 edge, wb_reg_write = 1 after 3 edges, retired_count = 1 after 4 edges.
- LW x5 followed by ADD x6,x5,x1 → stall = 1 for exactly one cycle and an EX bubble. Next cycle forward_a = 01 (load now in WB, ADD in EX).
- ADDI x7 followed by SW x7→mem → forward_b = 10 (store uses rs2). Repeat with a NOP gap → forward_b = 01. Repeat with destination x0 → forward_b = 00.
- A taken BEQ in EX with ex_branch_taken = 1, while LW x5 / ADD x6,x5 stall conditions are present in ID → flush_id = 1, stall = 0, ID/EX becomes a bubble, and retired_count excludes the flushed instruction.
- Unrecognized opcode, id_valid = 1 → illegal_trap pulses 1 cycle, no ex/mem/wb activity. The same input during a stall → no pulse until the stall clears.
- Force retired_count to 2^CNT_W − 1 (CNT_W = 4 instance), retire one instruction → retired_count = 0.
